// File: rtl/line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// line_ctrl_pkg
// Shared types and helpers for the line steering controller.
//   state_t  : controller state encoding (IDLE/TRACK/COAST/SEARCH)
//   X_W      : centroid width (pixels)
//   ERR_W    : signed error / filtered position width
//   DUTY_W   : duty width for the default PWM period
//   clamp()  : saturate an integer into [lo, hi]
// ---------------------------------------------------------------------------
package line_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_COAST  = 2'd2,
    ST_SEARCH = 2'd3
  } state_t;

  localparam int X_W            = 11;
  localparam int ERR_W          = 12;
  localparam int LOST_W         = 4;
  localparam int DEF_PWM_PERIOD = 1000;
  localparam int DUTY_W         = $clog2(DEF_PWM_PERIOD + 1);

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/line_steer_ctrl_pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
// One PWM channel: holds the active duty, which is reloaded from the shadow
// duty only when the shared period counter wraps, and compares it against
// the counter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   cnt        : shared period counter value
//   wrap       : counter is on its last count; active duty reloads this edge
//   shadow     : duty requested by the controller
//   force_low  : gate the output low regardless of duty
//   pwm        : PWM output (high while cnt < active duty)
// ---------------------------------------------------------------------------
module pwm_gen
  import line_ctrl_pkg::*;
#(
  parameter int DW = DUTY_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cnt,
  input  logic          wrap,
  input  logic [DW-1:0] shadow,
  input  logic          force_low,
  output logic          pwm
);

  logic [DW-1:0] active_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg <= '0;
    end else if (wrap) begin
      active_reg <= shadow;
    end
  end

  // A duty of 0 never compares true; a duty equal to the period always does.
  assign pwm = !force_low && (cnt < active_reg);

endmodule

// File: rtl/line_steer_ctrl.sv
// ---------------------------------------------------------------------------
// line_steer_ctrl
// Per-frame closed-loop steering: samples the line centroid on frame_tick,
// IIR-filters it, forms an error about the image centre and drives a pair of
// PWM motor outputs through a TRACK/COAST/SEARCH state machine.
// Optional build macro: STEER_DERIV_EN adds a derivative term to the
// control law (prev_err register, no kick on acquisition).
// Ports:
//   clk, rst     : video clock, asynchronous active-high reset
//   frame_tick   : one-cycle per-frame strobe, inputs stable when high
//   centroid_x   : line centroid in pixels (clamped to IMG_W-1)
//   line_valid   : centroid trustworthy
//   line_lost    : no line found (overrides line_valid)
//   enable       : motion enable level; low forces IDLE and PWM low
//   pwm_left/right : motor PWM outputs
//   steer_err    : signed filt_x - IMG_W/2
//   state        : IDLE=0 TRACK=1 COAST=2 SEARCH=3
//   lost_cnt     : consecutive lost frames, saturating at 15
// ---------------------------------------------------------------------------
module line_steer_ctrl
  import line_ctrl_pkg::*;
#(
  parameter int IMG_W       = 640,
  parameter int PWM_PERIOD  = 1000,
  parameter int BASE_DUTY   = 600,
  parameter int KP_SHIFT    = 2,
  parameter int KD_SHIFT    = 3,
  parameter int ALPHA_SHIFT = 2,
  parameter int LOST_FRAMES = 8,
  parameter int SEARCH_DUTY = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic [X_W-1:0]    centroid_x,
  input  logic              line_valid,
  input  logic              line_lost,
  input  logic              enable,
  output logic              pwm_left,
  output logic              pwm_right,
  output logic [ERR_W-1:0]  steer_err,
  output logic [1:0]        state,
  output logic [LOST_W-1:0] lost_cnt
);

  localparam int                      DW       = $clog2(PWM_PERIOD + 1);
  localparam logic [X_W-1:0]          X_MAX    = X_W'(IMG_W - 1);
  localparam logic signed [ERR_W-1:0] CENTER   = ERR_W'(IMG_W / 2);
  localparam logic [LOST_W-1:0]       LOST_LIM = LOST_W'(LOST_FRAMES);
  localparam logic [LOST_W-1:0]       LOST_SAT = '1;
  localparam logic [DW-1:0]           SPIN     = DW'(SEARCH_DUTY);
  localparam logic [DW-1:0]           CNT_LAST = DW'(PWM_PERIOD - 1);

  // Stage 1: FSM, lost counter, filter
  state_t                  state_reg, state_next;
  logic [LOST_W-1:0]       lost_reg, lost_next;
  logic signed [ERR_W-1:0] filt_reg, filt_next;
  logic                    busy1_reg, busy1_next;
  logic                    upd_reg, upd_next;

  // Stage 2: error and shadow duties
  logic                    busy2_reg;
  logic signed [ERR_W-1:0] err_reg;
  logic [DW-1:0]           shadow_reg [2];

  // PWM period counter
  logic [DW-1:0]           cnt_reg;
  logic                    wrap;

  logic                    accept;
  logic                    good;
  logic [X_W-1:0]          x_clamp;
  logic signed [ERR_W-1:0] x_s;
  logic signed [ERR_W-1:0] filt_diff;
  logic signed [ERR_W-1:0] filt_smooth;
  logic [LOST_W-1:0]       lost_inc;

  logic signed [ERR_W-1:0] err_new;
  int                      err_i;
  int                      corr_i;
  logic [DW-1:0]           duty_calc [2];

`ifdef STEER_DERIV_EN
  logic                    acq_reg, acq_next;
  logic signed [ERR_W-1:0] prev_err_reg;
  int                      prev_i;
`endif

  // ------------------------------------------------------------------------
  // Sample qualification and filter arithmetic
  // ------------------------------------------------------------------------
  always_comb begin
    // Ticks landing while the two-stage pipeline is still busy are dropped.
    accept      = frame_tick && !busy1_reg && !busy2_reg;
    good        = line_valid && !line_lost;
    x_clamp     = (centroid_x > X_MAX) ? X_MAX : centroid_x;
    x_s         = {1'b0, x_clamp};
    filt_diff   = x_s - filt_reg;
    filt_smooth = filt_reg + (filt_diff >>> ALPHA_SHIFT);
    lost_inc    = (lost_reg == LOST_SAT) ? LOST_SAT : lost_reg + 1'b1;
  end

  // ------------------------------------------------------------------------
  // FSM next-state
  // ------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    lost_next  = lost_reg;
    filt_next  = filt_reg;
    busy1_next = 1'b0;
    upd_next   = 1'b0;
`ifdef STEER_DERIV_EN
    acq_next   = 1'b0;
`endif
    if (!enable) begin
      state_next = ST_IDLE;
      lost_next  = '0;
    end else if (accept) begin
      busy1_next = 1'b1;
      case (state_reg)
        ST_IDLE, ST_SEARCH: begin
          if (good) begin
            // Acquisition: jump straight to the measurement, no smoothing.
            state_next = ST_TRACK;
            filt_next  = x_s;
            lost_next  = '0;
            upd_next   = 1'b1;
`ifdef STEER_DERIV_EN
            acq_next   = 1'b1;
`endif
          end else if (state_reg == ST_SEARCH) begin
            lost_next = lost_inc;
          end
        end
        ST_TRACK: begin
          if (good) begin
            filt_next = filt_smooth;
            upd_next  = 1'b1;
          end else begin
            state_next = ST_COAST;
            lost_next  = LOST_W'(1);
          end
        end
        ST_COAST: begin
          if (good) begin
            state_next = ST_TRACK;
            lost_next  = '0;
            filt_next  = filt_smooth;
            upd_next   = 1'b1;
          end else begin
            lost_next = lost_inc;
            if (lost_inc >= LOST_LIM) begin
              state_next = ST_SEARCH;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      lost_reg  <= '0;
      filt_reg  <= CENTER;
      busy1_reg <= 1'b0;
      upd_reg   <= 1'b0;
`ifdef STEER_DERIV_EN
      acq_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      lost_reg  <= lost_next;
      filt_reg  <= filt_next;
      busy1_reg <= busy1_next;
      upd_reg   <= upd_next;
`ifdef STEER_DERIV_EN
      acq_reg   <= acq_next;
`endif
    end
  end

  // ------------------------------------------------------------------------
  // Control law, evaluated on the freshly updated filter value
  // ------------------------------------------------------------------------
  always_comb begin
    err_new = filt_reg - CENTER;
    err_i   = 32'(err_new);
    corr_i  = err_i >>> KP_SHIFT;
`ifdef STEER_DERIV_EN
    // On acquisition the previous error is taken as the current one so the
    // derivative term starts at zero.
    prev_i  = acq_reg ? err_i : 32'(prev_err_reg);
    corr_i  = corr_i + ((err_i - prev_i) >>> KD_SHIFT);
`endif
    duty_calc[0] = DW'(clamp(BASE_DUTY + corr_i, 0, PWM_PERIOD));
    duty_calc[1] = DW'(clamp(BASE_DUTY - corr_i, 0, PWM_PERIOD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy2_reg     <= 1'b0;
      err_reg       <= '0;
      shadow_reg[0] <= '0;
      shadow_reg[1] <= '0;
`ifdef STEER_DERIV_EN
      prev_err_reg  <= '0;
`endif
    end else begin
      busy2_reg <= busy1_reg;
      if (state_reg == ST_IDLE) begin
        shadow_reg[0] <= '0;
        shadow_reg[1] <= '0;
      end else if (busy1_reg && upd_reg) begin
        err_reg       <= err_new;
        shadow_reg[0] <= duty_calc[0];
        shadow_reg[1] <= duty_calc[1];
`ifdef STEER_DERIV_EN
        prev_err_reg  <= err_new;
`endif
      end else if (state_reg == ST_SEARCH) begin
        // Spin toward the side the line was last seen on.
        shadow_reg[0] <= err_reg[ERR_W-1] ? '0 : SPIN;
        shadow_reg[1] <= err_reg[ERR_W-1] ? SPIN : '0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Shared PWM period counter and the two output channels
  // ------------------------------------------------------------------------
  assign wrap = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
    end
  end

  logic [1:0] pwm_bus;

  for (genvar gi = 0; gi < 2; gi++) begin : g_pwm
    pwm_gen #(
      .DW(DW)
    ) u_pwm (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt_reg),
      .wrap      (wrap),
      .shadow    (shadow_reg[gi]),
      .force_low (state_reg == ST_IDLE),
      .pwm       (pwm_bus[gi])
    );
  end

  assign pwm_left  = pwm_bus[0];
  assign pwm_right = pwm_bus[1];
  assign steer_err = err_reg;
  assign state     = state_reg;
  assign lost_cnt  = lost_reg;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_steer_ctrl
// Scoreboard bench for line_steer_ctrl. A second instance with BASE_DUTY=900
// and KP_SHIFT=0 shares the inputs and is checked for duty saturation.
// ---------------------------------------------------------------------------
module tb_line_steer_ctrl;

  localparam int PER = 1000;
  localparam int S_IDLE = 0, S_TRACK = 1, S_COAST = 2, S_SEARCH = 3;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic [10:0] centroid_x;
  logic        line_valid;
  logic        line_lost;
  logic        enable;

  logic        pwm_l, pwm_r, pwm_lh, pwm_rh;
  logic [11:0] err, err_h;
  logic [1:0]  st, st_h;
  logic [3:0]  lc, lc_h;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    st;
    int    err;
    int    lc;
  } tick_exp_t;

  typedef struct {
    string tag;
    int    l;
    int    r;
  } pwm_exp_t;

  tick_exp_t tick_q[$];
  pwm_exp_t  pwm_q[$];

  line_steer_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .centroid_x(centroid_x),
    .line_valid(line_valid), .line_lost(line_lost), .enable(enable),
    .pwm_left(pwm_l), .pwm_right(pwm_r), .steer_err(err), .state(st),
    .lost_cnt(lc)
  );

  line_steer_ctrl #(.BASE_DUTY(900), .KP_SHIFT(0)) dut_hi (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .centroid_x(centroid_x),
    .line_valid(line_valid), .line_lost(line_lost), .enable(enable),
    .pwm_left(pwm_lh), .pwm_right(pwm_rh), .steer_err(err_h), .state(st_h),
    .lost_cnt(lc_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s12(input logic [11:0] v);
    logic signed [11:0] t;
    t = v;
    return 32'(t);
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one frame tick, then compare the T+2 outputs against the
  // expectation queued for it.
  task automatic do_tick(input string tag, input int x, input logic v,
                         input logic l, input int es, input int ee,
                         input int el);
    tick_exp_t e;
    e.tag = tag; e.st = es; e.err = ee; e.lc = el;
    tick_q.push_back(e);
    @(negedge clk);
    centroid_x = 11'(x); line_valid = v; line_lost = l; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    e = tick_q.pop_front();
    $display("tick %s: x=%0d v=%0b l=%0b -> state=%0d err=%0d lost=%0d",
             e.tag, x, v, l, st, s12(err), lc);
    check_val({e.tag, "_state"}, int'(st), e.st);
    check_val({e.tag, "_err"}, s12(err), e.err);
    check_val({e.tag, "_lost"}, int'(lc), e.lc);
    @(negedge clk);
  endtask

  // Let one wrap pass so the shadow duty is active, then count high cycles
  // over exactly one period.
  task automatic measure(input string tag, input int el, input int er,
                         output int hl, output int hr);
    pwm_exp_t e;
    int cl, cr;
    e.tag = tag; e.l = el; e.r = er;
    pwm_q.push_back(e);
    cl = 0; cr = 0; hl = 0; hr = 0;
    repeat (PER) @(negedge clk);
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      cl += int'(pwm_l);  cr += int'(pwm_r);
      hl += int'(pwm_lh); hr += int'(pwm_rh);
    end
    e = pwm_q.pop_front();
    $display("pwm %s: high L=%0d R=%0d of %0d", e.tag, cl, cr, PER);
    check_val({e.tag, "_dutyL"}, cl, e.l);
    check_val({e.tag, "_dutyR"}, cr, e.r);
  endtask

  task automatic wait_pwm_high(input string tag);
    int k;
    k = 0;
    while (pwm_l !== 1'b1 && k < 2 * PER) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * PER) check_val({tag, "_timeout"}, int'(pwm_l), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hl, hr, k;
    rst = 1'b1; enable = 1'b0; frame_tick = 1'b0;
    centroid_x = '0; line_valid = 1'b0; line_lost = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_state", int'(st), S_IDLE);
    check_val("rst_err", s12(err), 0);
    check_val("rst_lost", int'(lc), 0);
    check_val("rst_pwmL", int'(pwm_l), 0);
    check_val("rst_pwmR", int'(pwm_r), 0);
    rst = 1'b0;
    enable = 1'b1;

    // Out-of-range centroid clamps to 639 -> err 319.
    do_tick("clamp", 2047, 1'b1, 1'b0, S_TRACK, 319, 0);
    check_val("clamp_err_hi", s12(err_h), 319);
    measure("clamp", 679, 521, hl, hr);
    check_val("clamp_hi_dutyL", hl, 1000);
    check_val("clamp_hi_dutyR", hr, 581);

    // Centred acquisition, straight ahead.
    pulse_reset();
    do_tick("acq320", 320, 1'b1, 1'b0, S_TRACK, 0, 0);
    measure("acq320", 600, 600, hl, hr);

    // Smoothed update 320 -> 480 gives filt 360; a tick inside the busy
    // window must be ignored.
    tick_q.push_back('{tag: "x480", st: S_TRACK, err: 40, lc: 0});
    @(negedge clk);
    centroid_x = 11'd480; line_valid = 1'b1; line_lost = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    centroid_x = 11'd0; line_valid = 1'b0; line_lost = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    begin
      tick_exp_t e;
      e = tick_q.pop_front();
      $display("tick %s: state=%0d err=%0d lost=%0d", e.tag, st, s12(err), lc);
      check_val({e.tag, "_state"}, int'(st), e.st);
      check_val({e.tag, "_err"}, s12(err), e.err);
      check_val({e.tag, "_lost"}, int'(lc), e.lc);
    end
    @(negedge clk);
    measure("x480", 610, 590, hl, hr);

    // valid+lost together counts as lost.
    do_tick("vlost", 480, 1'b1, 1'b1, S_COAST, 40, 1);

    // Drop enable while PWM is high.
    wait_pwm_high("en_drop");
    enable = 1'b0;
    @(negedge clk);
    $display("en_drop: pwmL=%0b pwmR=%0b state=%0d", pwm_l, pwm_r, st);
    check_val("en_drop_pwmL", int'(pwm_l), 0);
    check_val("en_drop_pwmR", int'(pwm_r), 0);
    check_val("en_drop_state", int'(st), S_IDLE);
    enable = 1'b1;

    // Acquire left of centre, then lose the line.
    do_tick("acq280", 280, 1'b1, 1'b0, S_TRACK, -40, 0);
    for (int i = 1; i <= 17; i++) begin
      do_tick($sformatf("lost%0d", i), 0, 1'b0, 1'b1,
              (i < 8) ? S_COAST : S_SEARCH, -40, (i > 15) ? 15 : i);
      if (i == 3) measure("coast", 590, 610, hl, hr);
    end
    measure("search", 0, 400, hl, hr);

    // Reacquire from SEARCH: filter reloads to 100.
    do_tick("reacq", 100, 1'b1, 1'b0, S_TRACK, -220, 0);
    measure("reacq", 545, 655, hl, hr);

    // Asynchronous reset mid-period while PWM is high.
    wait_pwm_high("arst");
    #2 rst = 1'b1;
    #1;
    $display("arst: pwmL=%0b pwmR=%0b state=%0d", pwm_l, pwm_r, st);
    check_val("arst_pwmL", int'(pwm_l), 0);
    check_val("arst_pwmR", int'(pwm_r), 0);
    check_val("arst_state", int'(st), S_IDLE);
    check_val("arst_err", s12(err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Counter restarts at 0: the first wrap after release is on the 1000th
    // edge, so PWM stays low until then despite a new 600 shadow duty.
    do_tick("post_rst", 320, 1'b1, 1'b0, S_TRACK, 0, 0);
    k = 4;
    while (pwm_l !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    $display("post_rst: first PWM high at edge %0d", k);
    check_val("post_rst_first_high", k, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_steer_ctrl.md
Name: line_steer_ctrl

Overview:
- Closed-loop steering stage directly downstream of calc_centroid, in the clk_video domain.
- Once per frame, samples centroid_x, line_valid and line_lost, low-pass filters the centroid and forms an error about the image centre.
- Drives two PWM motor outputs, left and right, through a TRACK/COAST/SEARCH state machine that handles line loss.

Parameters:
- IMG_W, 640: image width in pixels; centre = IMG_W/2.
- PWM_PERIOD, 1000: PWM period in clk cycles.
- BASE_DUTY, 600: straight-ahead duty, in counts.
- KP_SHIFT, 2: proportional gain, as an arithmetic right shift of the error.
- KD_SHIFT, 3: derivative gain shift; used only with STEER_DERIV_EN.
- ALPHA_SHIFT, 2: IIR smoothing shift.
- LOST_FRAMES, 8: consecutive lost frames before SEARCH.
- SEARCH_DUTY, 400: spin duty in SEARCH.

Ports:
- clk  in  1  pixel/video clock.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame; centroid inputs are stable when it fires.
- centroid_x  in  11  unsigned line centroid, in pixels.
- line_valid  in  1  centroid is trustworthy this frame.
- line_lost  in  1  no line found this frame.
- enable  in  1  motion enable, level.
- pwm_left  out  1  left motor PWM.
- pwm_right  out  1  right motor PWM.
- steer_err  out  12  signed error, filt_x - IMG_W/2.
- state  out  2  IDLE=0, TRACK=1, COAST=2, SEARCH=3.
- lost_cnt  out  4  consecutive lost frames, saturating.

Behaviour:
- Reset (async):
  - state = IDLE; filt_x = IMG_W/2.
  - steer_err, lost_cnt, all duties, PWM counter, pwm_left, pwm_right = 0.
- Sample qualification:
  - A frame is "good" when line_valid=1 and line_lost=0.
  - line_valid=1 with line_lost=1 counts as lost.
  - centroid_x >= IMG_W is clamped to IMG_W-1 before use.
- Pipeline:
  - Cycle T+1 after frame_tick: filt_x updated.
  - Cycle T+2: steer_err and shadow duties registered; state transitions take effect at T+1.
  - A frame_tick arriving while the pipeline is busy (T+1, T+2) is dropped.
- Filter on a good frame in TRACK/COAST:
  - filt_x += (x - filt_x) >>> ALPHA_SHIFT, signed 12-bit arithmetic.
  - On acquisition from IDLE or SEARCH, filt_x = x (no smoothing).
- Control law:
  - corr = steer_err >>> KP_SHIFT.
  - dutyL = clamp(BASE_DUTY + corr, 0, PWM_PERIOD).
  - dutyR = clamp(BASE_DUTY - corr, 0, PWM_PERIOD).
- State machine:
  - IDLE: shadow duties 0. On a good tick with enable=1, go to TRACK.
  - TRACK: a good tick updates filter and duties. A non-good tick goes to COAST with lost_cnt=1; duties are held.
  - COAST: a good tick goes to TRACK, lost_cnt=0, normal update. A non-good tick increments lost_cnt; when lost_cnt reaches LOST_FRAMES, go to SEARCH.
  - SEARCH:
    - Spin toward the sign of the last steer_err: err>=0 gives L=SEARCH_DUTY, R=0; err<0 gives L=0, R=SEARCH_DUTY.
    - A good tick goes to TRACK, reloads filt_x and sets lost_cnt=0.
  - enable=0 in any state forces IDLE on the next cycle; pwm outputs are forced low on that cycle, ignoring the shadow.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1.
  - The active duty loads from the shadow only at counter wrap, so there are no mid-period glitches.
  - Output = (cnt < active_duty): duty 0 gives constant low; duty PWM_PERIOD gives constant high.
- lost_cnt saturates at 15.

Optional Feature:
- Macro STEER_DERIV_EN.
- Defined:
  - corr = (err >>> KP_SHIFT) + ((err - prev_err) >>> KD_SHIFT).
  - prev_err is registered on each update.
  - On acquisition from IDLE or SEARCH, prev_err = err, so there is no derivative kick.
- Undefined: proportional only; no prev_err register; KD_SHIFT ignored.

Decomposition:
- Package line_ctrl_pkg:
  - state enum.
  - X_W=11, ERR_W=12, DUTY_W=$clog2(PWM_PERIOD+1).
  - clamp function.
- Sub-module pwm_gen: counter, shadow/active duty and compare; instantiated twice (left, right), shared wrap.

Test Plan:
- Reset, enable=1, good tick x=320 -> TRACK, steer_err=0. After the next wrap, both PWMs are high 600 of every 1000 cycles.
- Acquire x=320, then good tick x=480 -> filt_x=360, err=40, corr=10; dutyL=610, dutyR=590, applied only from the following wrap.
- Override BASE_DUTY=900, KP_SHIFT=0; acquire x=2047 -> clamped to 639, err=319; dutyL=1000 (constant high), dutyR=581.
- TRACK with err=-40, then ticks with line_lost=1:
  - Ticks 1-7: COAST, duties held, lost_cnt 1..7.
  - Tick 8: SEARCH, L=0, R=400.
  - Then good tick x=100: TRACK, filt_x=100, lost_cnt=0.
- In TRACK, a tick with line_valid=1 and line_lost=1 -> COAST. Dropping enable mid-period -> pwm low next cycle, state=IDLE.
- Assert rst mid-period with pwm high -> pwm low immediately (async), state=IDLE. After release, the counter restarts at 0.
